// File: rtl/glyph_text_renderer.sv
// glyph_text_renderer
//   Text overlay for the video path. A string of NUM_CHARS glyph codes is
//   drawn at a frame-latched origin with 1x/2x/4x/8x integer scaling. The
//   block returns one on/off pixel per input pixel, three cycles after the
//   matching hcount/vcount/valid sample, and never stalls.
//
// Ports
//   clk_in        sole clock
//   rst_n_in      asynchronous active-low reset
//   hcount_in     current pixel x
//   vcount_in     current pixel y
//   valid_in      hcount_in/vcount_in is an active pixel
//   x_in, y_in    text origin, latched when hcount_in==0 && vcount_in==0
//   scale_in      log2 scale factor, latched with the origin
//   char_we_in    string buffer write strobe
//   char_idx_in   string slot to write
//   char_code_in  glyph code to store in the slot
//   font_we_in    font row write strobe
//   font_addr_in  font row address (code*GLYPH_H + row)
//   font_data_in  font row bits, MSB is the leftmost pixel
//   pixel_out     glyph pixel is lit
//   valid_out     valid_in delayed by three cycles
module glyph_text_renderer #(
  parameter int    GLYPH_W    = 16,
  parameter int    GLYPH_H    = 16,
  parameter int    NUM_GLYPHS = 20,
  parameter int    NUM_CHARS  = 8,
  parameter int    BLANK_CODE = 16,
  parameter string INIT_FILE  = "font.mem",
  localparam int   CW = $clog2(NUM_GLYPHS),
  localparam int   AW = $clog2(NUM_GLYPHS*GLYPH_H),
  localparam int   IW = $clog2(NUM_CHARS)
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic               valid_in,
  input  logic [10:0]        x_in,
  input  logic [9:0]         y_in,
  input  logic [1:0]         scale_in,
  input  logic               char_we_in,
  input  logic [IW-1:0]      char_idx_in,
  input  logic [CW-1:0]      char_code_in,
  input  logic               font_we_in,
  input  logic [AW-1:0]      font_addr_in,
  input  logic [GLYPH_W-1:0] font_data_in,
  output logic               pixel_out,
  output logic               valid_out
);

  localparam int          DEPTH   = NUM_GLYPHS*GLYPH_H;
  localparam int          GWL     = $clog2(GLYPH_W);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);
  localparam logic [31:0] NG_U    = 32'(NUM_GLYPHS);

  // Geometry shadows and string buffer
  logic [10:0]   sx_q;
  logic [9:0]    sy_q;
  logic [1:0]    ss_q;
  logic [CW-1:0] chars_q [NUM_CHARS];

  // Font memory and its write port, which is delayed one cycle so that it
  // lines up with the read issued by a pixel sampled in the same cycle
  logic [GLYPH_W-1:0] font_mem [DEPTH];
  logic               fw_we_q;
  logic [AW-1:0]      fw_addr_q;
  logic [GLYPH_W-1:0] fw_data_q;

  // Stage 0 (combinational address generation)
  logic          frame_start_p0;
  logic [10:0]   dx_p0, dy_p0, dxs_p0, idx_p0, row_p0;
  logic [11:0]   box_w_p0, box_h_p0;
  logic          inbox_p0, codeok_p0;
  logic [CW-1:0] code_p0;
  logic          hit_p1_d;
  logic [AW-1:0] addr_p1_d;
  logic [GWL-1:0] col_p1_d;

  // Pipeline registers
  logic               vld_p1_q, hit_p1_q;
  logic [AW-1:0]      addr_p1_q;
  logic [GWL-1:0]     col_p1_q;
  logic               vld_p2_q, hit_p2_q;
  logic [GWL-1:0]     col_p2_q;
  logic [GLYPH_W-1:0] rdata_p2_q;
  logic               pixel_d;
  logic               pixel_q, valid_q;

  assign frame_start_p0 = (hcount_in == 11'd0) && (vcount_in == 10'd0);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sx_q <= '0;
      sy_q <= '0;
      ss_q <= '0;
    end else if (frame_start_p0) begin
      sx_q <= x_in;
      sy_q <= y_in;
      ss_q <= scale_in;
    end
  end

  // Slots outside 0..NUM_CHARS-1 never match, so such writes are dropped
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_CHARS; i++) chars_q[i] <= CW'(BLANK_CODE);
    end else if (char_we_in) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        if (char_idx_in == IW'(i)) chars_q[i] <= char_code_in;
      end
    end
  end

  // Stage 0 -> stage 1: box test, glyph lookup, font row address
  always_comb begin
    dx_p0    = hcount_in - sx_q;
    dy_p0    = {1'b0, vcount_in} - {1'b0, sy_q};
    box_w_p0 = 12'(NUM_CHARS*GLYPH_W) << ss_q;
    box_h_p0 = 12'(GLYPH_H) << ss_q;
    // The >= terms stop origins near the counter maximum from wrapping
    inbox_p0 = (hcount_in >= sx_q) && (vcount_in >= sy_q) &&
               ({1'b0, dx_p0} < box_w_p0) && ({1'b0, dy_p0} < box_h_p0);
    dxs_p0   = dx_p0 >> ss_q;
    idx_p0   = dxs_p0 >> GWL;
    row_p0   = dy_p0 >> ss_q;
    col_p1_d = dxs_p0[GWL-1:0];
    code_p0  = CW'(BLANK_CODE);
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (idx_p0 == 11'(i)) code_p0 = chars_q[i];
    end
    codeok_p0 = 32'(code_p0) < NG_U;
    hit_p1_d  = inbox_p0 && codeok_p0;
    // Misses read row 0 so the read address always stays inside the font
    addr_p1_d = hit_p1_d ? (AW'(code_p0) * AW'(GLYPH_H) + AW'(row_p0)) : '0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_p1_q <= 1'b0;
      hit_p1_q <= 1'b0;
      fw_we_q  <= 1'b0;
    end else begin
      vld_p1_q <= valid_in;
      hit_p1_q <= hit_p1_d;
      fw_we_q  <= font_we_in;
    end
  end

  always_ff @(posedge clk_in) begin
    addr_p1_q <= addr_p1_d;
    col_p1_q  <= col_p1_d;
    fw_addr_q <= font_addr_in;
    fw_data_q <= font_data_in;
  end

  // Stage 1 -> stage 2: font read, read-first against the delayed write
  always_ff @(posedge clk_in) begin
    if (fw_we_q && (32'(fw_addr_q) < DEPTH_U)) font_mem[fw_addr_q] <= fw_data_q;
    rdata_p2_q <= font_mem[addr_p1_q];
    col_p2_q   <= col_p1_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_p2_q <= 1'b0;
      hit_p2_q <= 1'b0;
    end else begin
      vld_p2_q <= vld_p1_q;
      hit_p2_q <= hit_p1_q;
    end
  end

  // Stage 2 -> stage 3: bit select; GLYPH_W is a power of two, so
  // GLYPH_W-1-col is simply the bitwise complement of col
  assign pixel_d = vld_p2_q && hit_p2_q && rdata_p2_q[~col_p2_q];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pixel_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pixel_q <= pixel_d;
      valid_q <= vld_p2_q;
    end
  end

  assign pixel_out = pixel_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_glyph_text_renderer.sv
module tb_glyph_text_renderer;
  localparam int GW = 16, GH = 16, NG = 20, NC = 8, BLANK = 16;
  localparam int DEPTH = NG*GH;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b1;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        valid_in = 1'b0;
  logic [10:0] x_in = '0;
  logic [9:0]  y_in = '0;
  logic [1:0]  scale_in = '0;
  logic        char_we_in = 1'b0;
  logic [2:0]  char_idx_in = '0;
  logic [4:0]  char_code_in = '0;
  logic        font_we_in = 1'b0;
  logic [8:0]  font_addr_in = '0;
  logic [15:0] font_data_in = '0;
  logic        pixel_out, valid_out;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_font [DEPTH];
  int          m_chars [NC];
  int          m_sx, m_sy, m_ss;
  bit [1:0]    expq[$];
  bit          have_q, exp_v, exp_p;

  glyph_text_renderer #(.INIT_FILE("")) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .valid_in(valid_in),
    .x_in(x_in), .y_in(y_in), .scale_in(scale_in),
    .char_we_in(char_we_in), .char_idx_in(char_idx_in), .char_code_in(char_code_in),
    .font_we_in(font_we_in), .font_addr_in(font_addr_in), .font_data_in(font_data_in),
    .pixel_out(pixel_out), .valid_out(valid_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Expected pixel from the geometric definition of the text box
  function automatic bit ref_pix(int h, int v);
    int scl, dx, dy, code;
    scl = 1 << m_ss;
    dx  = h - m_sx;
    dy  = v - m_sy;
    if (dx < 0 || dy < 0 || dx >= NC*GW*scl || dy >= GH*scl) return 1'b0;
    code = m_chars[dx / (GW*scl)];
    if (code >= NG) return 1'b0;
    return m_font[code*GH + dy/scl][GW-1 - (dx/scl) % GW];
  endfunction

  // One clock: predict with the state before this cycle's updates, then apply them
  task automatic cyc();
    bit e;
    e = valid_in && ref_pix(int'(hcount_in), int'(vcount_in));
    expq.push_back({valid_in, e});
    if (char_we_in) m_chars[char_idx_in] = int'(char_code_in);
    if (font_we_in && int'(font_addr_in) < DEPTH) m_font[font_addr_in] = font_data_in;
    if (hcount_in == 11'd0 && vcount_in == 10'd0) begin
      m_sx = int'(x_in); m_sy = int'(y_in); m_ss = int'(scale_in);
    end
    @(posedge clk_in); #1;
    have_q = 1'b0; exp_v = 1'b0; exp_p = 1'b0;
    if (expq.size() >= 3) begin
      {exp_v, exp_p} = expq.pop_front();
      have_q = 1'b1;
    end
  endtask

  task automatic idle_in();
    valid_in = 1'b0; hcount_in = 11'd1; vcount_in = 10'd1;
    char_we_in = 1'b0; font_we_in = 1'b0;
  endtask

  task automatic wr_font(int a, logic [15:0] d);
    idle_in(); font_we_in = 1'b1; font_addr_in = 9'(a); font_data_in = d;
    cyc(); idle_in();
  endtask

  task automatic wr_char(int i, int c);
    idle_in(); char_we_in = 1'b1; char_idx_in = 3'(i); char_code_in = 5'(c);
    cyc(); idle_in();
  endtask

  task automatic frame(int x, int y, int s);
    idle_in(); x_in = 11'(x); y_in = 10'(y); scale_in = 2'(s);
    hcount_in = 11'd0; vcount_in = 10'd0;
    cyc(); idle_in();
  endtask

  // Drive one pixel and return the outputs three clocks later
  task automatic probe(int h, int v, output logic vo, output logic po);
    idle_in(); hcount_in = 11'(h); vcount_in = 10'(v); valid_in = 1'b1;
    cyc(); idle_in(); cyc(); cyc();
    vo = valid_out; po = pixel_out;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NC; i++) m_chars[i] = BLANK;
    m_sx = 0; m_sy = 0; m_ss = 0;
    rst_n_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      hcount_in = 11'(100 + i); vcount_in = 10'd50; valid_in = 1'b1;
      @(posedge clk_in); #1;
      checks++;
      if (pixel_out !== 1'b0 || valid_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: pixel_out=%b valid_out=%b required 0/0", pixel_out, valid_out);
      end
    end
    rst_n_in = 1'b1;
    idle_in();
    expq.delete(); expq.push_back(2'b00); expq.push_back(2'b00);
    for (int a = 0; a < DEPTH; a++)
      wr_font(a, (a >= BLANK*GH && a < (BLANK+1)*GH) ? 16'h0000 : 16'($urandom));
    hcount_in = 11'd5; vcount_in = 10'd5; valid_in = 1'b1;
    cyc(); idle_in();
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL first_valid_c1: valid_out=%b required 0", valid_out); end
    cyc();
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL first_valid_c2: valid_out=%b required 0", valid_out); end
    cyc();
    checks++;
    if (valid_out !== 1'b1 || pixel_out !== 1'b0) begin
      errors++;
      $display("FAIL unwritten_buffer: valid_out=%b pixel_out=%b required 1/0", valid_out, pixel_out);
    end
  endtask

  task automatic test_basic_1x();
    int ph[4] = '{100, 101, 115, 116};
    bit pe[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic vo, po;
    wr_font(48, 16'h8001);
    wr_char(0, 3);
    frame(100, 50, 0);
    for (int i = 0; i < 4; i++) begin
      probe(ph[i], 50, vo, po);
      checks++;
      if (vo !== 1'b1 || po !== pe[i]) begin
        errors++;
        $display("FAIL basic_1x(%0d,50): valid_out=%b pixel_out=%b required 1/%b", ph[i], vo, po, pe[i]);
      end
    end
  endtask

  task automatic test_scale_2x();
    int ph[8] = '{100, 101, 100, 101, 102, 130, 131, 132};
    int pv[8] = '{ 50,  50,  51,  51,  50,  50,  51,  50};
    bit pe[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic vo, po;
    frame(100, 50, 1);
    for (int i = 0; i < 8; i++) begin
      probe(ph[i], pv[i], vo, po);
      checks++;
      if (vo !== 1'b1 || po !== pe[i]) begin
        errors++;
        $display("FAIL scale_2x(%0d,%0d): valid_out=%b pixel_out=%b required 1/%b", ph[i], pv[i], vo, po, pe[i]);
      end
    end
  endtask

  task automatic test_bounds();
    logic vo, po;
    frame(100, 50, 0);
    probe(99, 50, vo, po); checks++;
    if (po !== 1'b0) begin errors++; $display("FAIL bounds_left: pixel_out=%b required 0", po); end
    probe(100, 66, vo, po); checks++;
    if (po !== 1'b0) begin errors++; $display("FAIL bounds_bottom: pixel_out=%b required 0", po); end
    wr_char(7, 3);
    probe(227, 50, vo, po); checks++;
    if (po !== 1'b1) begin errors++; $display("FAIL bounds_last_col: pixel_out=%b required 1", po); end
    probe(228, 50, vo, po); checks++;
    if (po !== 1'b0) begin errors++; $display("FAIL bounds_right: pixel_out=%b required 0", po); end
    wr_char(0, 31);
    probe(100, 50, vo, po); checks++;
    if (po !== 1'b0) begin errors++; $display("FAIL bounds_bad_code: pixel_out=%b required 0", po); end
    wr_char(0, 3);
    frame(2040, 1020, 0);
    wr_char(1, 3);
    probe(2040, 1020, vo, po); checks++;
    if (po !== 1'b1) begin errors++; $display("FAIL wrap_origin: pixel_out=%b required 1", po); end
    probe(8, 1020, vo, po); checks++;
    if (po !== 1'b0) begin errors++; $display("FAIL wrap_x: pixel_out=%b required 0", po); end
    probe(2040, 4, vo, po); checks++;
    if (po !== 1'b0) begin errors++; $display("FAIL wrap_y: pixel_out=%b required 0", po); end
    wr_char(1, BLANK);
  endtask

  task automatic test_shadowing();
    logic vo, po;
    frame(100, 50, 0);
    x_in = 11'd200;
    probe(100, 50, vo, po); checks++;
    if (po !== 1'b1) begin errors++; $display("FAIL shadow_old_lit: pixel_out=%b required 1", po); end
    probe(200, 50, vo, po); checks++;
    if (po !== 1'b0) begin errors++; $display("FAIL shadow_new_dark: pixel_out=%b required 0", po); end
    frame(200, 50, 0);
    probe(200, 50, vo, po); checks++;
    if (po !== 1'b1) begin errors++; $display("FAIL shadow_new_lit: pixel_out=%b required 1", po); end
    probe(100, 50, vo, po); checks++;
    if (po !== 1'b0) begin errors++; $display("FAIL shadow_old_dark: pixel_out=%b required 0", po); end
    x_in = 11'd0; y_in = 10'd0; scale_in = 2'd0;
    probe(0, 0, vo, po); checks++;
    if (vo !== 1'b1 || po !== 1'b0) begin
      errors++; $display("FAIL frame_pixel_old_shadow: valid_out=%b pixel_out=%b required 1/0", vo, po);
    end
    probe(15, 0, vo, po); checks++;
    if (po !== 1'b1) begin errors++; $display("FAIL frame_pixel_after_load: pixel_out=%b required 1", po); end
  endtask

  task automatic test_collision();
    frame(100, 50, 0);
    idle_in(); font_we_in = 1'b1; font_addr_in = 9'd48; font_data_in = 16'h0000;
    hcount_in = 11'd100; vcount_in = 10'd50; valid_in = 1'b1;
    cyc();
    idle_in(); hcount_in = 11'd100; vcount_in = 10'd50; valid_in = 1'b1;
    cyc();
    idle_in();
    cyc(); checks++;
    if (pixel_out !== 1'b1) begin errors++; $display("FAIL collision_old_data: pixel_out=%b required 1", pixel_out); end
    cyc(); checks++;
    if (pixel_out !== 1'b0) begin errors++; $display("FAIL collision_new_data: pixel_out=%b required 0", pixel_out); end
    wr_font(48, 16'h8001);
  endtask

  task automatic test_random();
    int h, v;
    for (int n = 0; n < 1500; n++) begin
      idle_in();
      if ($urandom_range(0, 19) == 0) begin
        x_in = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(1990, 2047)) : 11'($urandom_range(0, 1900));
        y_in = 10'($urandom_range(0, 1023));
        scale_in = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 29) == 0) begin
        hcount_in = 11'd0; vcount_in = 10'd0;
        valid_in = 1'($urandom_range(0, 1));
      end else begin
        h = m_sx + $urandom_range(0, (NC*GW << m_ss) + 8) - 4;
        v = m_sy + $urandom_range(0, (GH << m_ss) + 4) - 2;
        hcount_in = 11'(h); vcount_in = 10'(v);
        valid_in = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 9) == 0) begin
        char_we_in = 1'b1; char_idx_in = 3'($urandom_range(0, 7));
        char_code_in = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 19));
      end
      if ($urandom_range(0, 9) == 0) begin
        font_we_in = 1'b1; font_addr_in = 9'($urandom_range(0, 511));
        font_data_in = 16'($urandom);
      end
      cyc();
      if (have_q) begin
        checks++;
        if (valid_out !== exp_v || pixel_out !== exp_p) begin
          errors++;
          $display("FAIL random_stream[%0d]: valid_out=%b pixel_out=%b required %b/%b", n, valid_out, pixel_out, exp_v, exp_p);
        end
      end
    end
    idle_in();
  endtask

  task automatic test_async_reset();
    wr_char(0, 3);
    wr_font(48, 16'h8001);
    frame(100, 50, 0);
    hcount_in = 11'd100; vcount_in = 10'd50; valid_in = 1'b1;
    cyc(); cyc(); cyc();
    checks++;
    if (valid_out !== 1'b1 || pixel_out !== 1'b1) begin
      errors++; $display("FAIL pre_reset_stream: valid_out=%b pixel_out=%b required 1/1", valid_out, pixel_out);
    end
    #2 rst_n_in = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || pixel_out !== 1'b0) begin
      errors++; $display("FAIL async_reset_clear: valid_out=%b pixel_out=%b required 0/0", valid_out, pixel_out);
    end
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    idle_in();
  endtask

  initial begin
    test_reset();
    test_basic_1x();
    test_scale_2x();
    test_bounds();
    test_shadowing();
    test_collision();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
